// File: rtl/tf_bus_pkg.sv
// Shared definitions for the 68030-style local bus master: FSM states,
// SIZ and DSACK encodings, strobe polarities and small encoding helpers.
package tf_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STROBE,
    ST_WAIT,
    ST_TERM,
    ST_DONE
  } bus_state_e;

  // SIZ encoding of the bytes still to transfer
  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  // DSACK codes (active low) returned by the responder, giving its port width
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  localparam logic BERR_ACTIVE = 1'b0;

  // WAIT cycles allowed before a missing termination becomes a bus error
  localparam int TIMEOUT = 255;

  // Operand length field (SIZ encoding) to a byte count of 1..4
  function automatic logic [2:0] rem_from_len(input logic [1:0] len);
    return (len == SIZ_LONG) ? 3'd4 : {1'b0, len};
  endfunction

  // Byte count of 1..4 back to SIZ encoding
  function automatic logic [1:0] siz_from_rem(input logic [2:0] rem);
    case (rem)
      3'd1:    return SIZ_BYTE;
      3'd2:    return SIZ_WORD;
      3'd3:    return SIZ_3BYTE;
      default: return SIZ_LONG;
    endcase
  endfunction

  // Mask that keeps the low 'len' bytes of a right-justified operand
  function automatic logic [31:0] len_mask(input logic [2:0] len);
    case (len)
      3'd1:    return 32'h0000_00FF;
      3'd2:    return 32'h0000_FFFF;
      3'd3:    return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/bus_lane_mux.sv
// Dynamic bus sizing datapath: how many bytes a terminated cycle takes,
// which read lanes they come from, and how write bytes are placed on lanes.
module bus_lane_mux
  import tf_bus_pkg::*;
(
  input  logic [1:0]  port,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  rem,
  input  logic [31:0] opr,
  input  logic [31:0] d_in,
  output logic [2:0]  n,
  output logic [31:0] rd_bytes,
  output logic [31:0] wr_lanes
);

  logic [2:0] avail;
  logic [1:0] src;
  logic [2:0] drop;
  logic [31:0] rep;
  logic [7:0]  rep_b [4];
  logic [1:0]  sel;

  // Bytes taken this cycle and the right-justified read bytes from their lanes
  always_comb begin
    avail = 3'd1;
    src   = 2'd0;
    case (port)
      DSACK_32: begin
        avail = 3'd4 - {1'b0, addr_lo};
        src   = addr_lo;
      end
      DSACK_16: begin
        avail = 3'd2 - {2'b00, addr_lo[0]};
        src   = {1'b0, addr_lo[0]};
      end
      DSACK_8: begin
        avail = 3'd1;
        src   = 2'd0;
      end
      default: begin
        avail = 3'd1;
        src   = 2'd0;
      end
    endcase
    n        = (rem < avail) ? rem : avail;
    drop     = 3'd4 - n;
    rd_bytes = (d_in << {src, 3'b000}) >> {drop, 3'b000};
  end

  // Write lanes: remaining bytes repeat so narrow ports always see O0 on their lanes
  always_comb begin
    case (rem)
      3'd1:    rep = {4{opr[31:24]}};
      3'd2:    rep = {2{opr[31:16]}};
      3'd3:    rep = {opr[31:8], opr[31:24]};
      default: rep = opr;
    endcase
    for (int k = 0; k < 4; k++) begin
      rep_b[k] = rep[31-8*k -: 8];
    end
    wr_lanes = '0;
    sel      = 2'd0;
    for (int j = 0; j < 4; j++) begin
      if (j >= int'(addr_lo)) begin
        sel = 2'(j - int'(addr_lo));
      end else if (j < 2 && j >= int'(addr_lo[0])) begin
        sel = 2'(j - int'(addr_lo[0]));
      end else begin
        sel = 2'd0;
      end
      wr_lanes[31-8*j -: 8] = rep_b[sel];
    end
  end

endmodule

// File: rtl/cpu_bus_master.sv
// Single-request to 68030-style asynchronous bus cycle initiator with
// dynamic bus sizing, BERR handling and a WAIT timeout. All outputs registered.
module cpu_bus_master
  import tf_bus_pkg::*;
(
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        REQ,
  input  logic        REQ_RW,
  input  logic [23:0] REQ_A,
  input  logic [1:0]  REQ_LEN,
  input  logic [31:0] REQ_WDATA,
  output logic        ACK,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        BUSY,
  output logic [23:0] A,
  output logic [1:0]  SIZ,
  output logic        AS20,
  output logic        DS20,
  output logic        RW20,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  input  logic [31:0] D_IN,
  input  logic [1:0]  DSACK,
  input  logic        BERR
);

  bus_state_e  state_q, state_d;
  logic [23:0] a_q, a_d;
  logic [2:0]  rem_q, rem_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] opr_q, opr_d;
  logic        rw_q, rw_d;
  logic        err_flag_q, err_flag_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [1:0]  port_q, port_d;
  logic [1:0]  siz_q, siz_d;
  logic        as20_q, as20_d;
  logic        ds20_q, ds20_d;
  logic        rw20_q, rw20_d;
  logic [31:0] d_out_q, d_out_d;
  logic        d_oe_q, d_oe_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;

  logic [2:0]  n;
  logic [31:0] rd_bytes;
  logic [31:0] wr_lanes;

  bus_lane_mux u_lane_mux (
    .port     (port_q),
    .addr_lo  (a_q[1:0]),
    .rem      (rem_q),
    .opr      (opr_q),
    .d_in     (D_IN),
    .n        (n),
    .rd_bytes (rd_bytes),
    .wr_lanes (wr_lanes)
  );

  // Sequencing of bus cycles and the request/address/operand bookkeeping
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    rem_d      = rem_q;
    len_d      = len_q;
    opr_d      = opr_q;
    rw_d       = rw_q;
    err_flag_d = err_flag_q;
    tmo_d      = tmo_q;
    port_d     = port_q;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          a_d        = REQ_A;
          rem_d      = rem_from_len(REQ_LEN);
          len_d      = rem_d;
          rw_d       = REQ_RW;
          err_flag_d = 1'b0;
          opr_d      = REQ_RW ? 32'h0 : (REQ_WDATA << {3'd4 - rem_d, 3'b000});
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        tmo_d   = '0;
        state_d = ST_STROBE;
      end
      ST_STROBE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (BERR == BERR_ACTIVE) begin
          err_flag_d = 1'b1;
          state_d    = ST_TERM;
        end else if (DSACK != DSACK_NONE) begin
          port_d  = DSACK;
          state_d = ST_TERM;
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          err_flag_d = 1'b1;
          state_d    = ST_TERM;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_TERM: begin
        if (!err_flag_q) begin
          opr_d = (opr_q << {n, 3'b000}) | (rw_q ? rd_bytes : 32'h0);
          a_d   = a_q + 24'(n);
          rem_d = rem_q - n;
        end
        state_d = (err_flag_q || rem_d == 3'd0) ? ST_DONE : ST_ADDR;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus and handshake outputs decoded from the next state so they register cleanly
  always_comb begin
    siz_d   = siz_q;
    rw20_d  = rw20_q;
    d_out_d = d_out_q;
    rdata_d = rdata_q;
    as20_d  = !(state_d inside {ST_STROBE, ST_WAIT});
    ds20_d  = !((state_d == ST_STROBE && rw_d) || state_d == ST_WAIT);
    d_oe_d  = !rw_d && (state_d inside {ST_STROBE, ST_WAIT, ST_TERM});
    ack_d   = (state_d == ST_DONE);
    err_d   = (state_d == ST_DONE) && err_flag_d;
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_ADDR) begin
      siz_d  = siz_from_rem(rem_d);
      rw20_d = rw_d;
    end
    if (state_d == ST_STROBE && !rw_d) begin
      d_out_d = wr_lanes;
    end
    if (state_d == ST_DONE && rw_q) begin
      rdata_d = opr_d & len_mask(len_q);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLKCPU) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      opr_q      <= '0;
      rw_q       <= 1'b1;
      err_flag_q <= 1'b0;
      tmo_q      <= '0;
      port_q     <= DSACK_NONE;
      siz_q      <= SIZ_LONG;
      as20_q     <= 1'b1;
      ds20_q     <= 1'b1;
      rw20_q     <= 1'b1;
      d_out_q    <= '0;
      d_oe_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      opr_q      <= opr_d;
      rw_q       <= rw_d;
      err_flag_q <= err_flag_d;
      tmo_q      <= tmo_d;
      port_q     <= port_d;
      siz_q      <= siz_d;
      as20_q     <= as20_d;
      ds20_q     <= ds20_d;
      rw20_q     <= rw20_d;
      d_out_q    <= d_out_d;
      d_oe_q     <= d_oe_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign A     = a_q;
  assign SIZ   = siz_q;
  assign AS20  = as20_q;
  assign DS20  = ds20_q;
  assign RW20  = rw20_q;
  assign D_OUT = d_out_q;
  assign D_OE  = d_oe_q;
  assign ACK   = ack_q;
  assign ERR   = err_q;
  assign RDATA = rdata_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master: a table of single requests answered by a
// simple responder model, plus hand-written timeout and reset-in-WAIT sequences.
module tb_cpu_bus_master;

  logic        CLKCPU;
  logic        RESET;
  logic        REQ;
  logic        REQ_RW;
  logic [23:0] REQ_A;
  logic [1:0]  REQ_LEN;
  logic [31:0] REQ_WDATA;
  logic        ACK;
  logic        ERR;
  logic [31:0] RDATA;
  logic        BUSY;
  logic [23:0] A;
  logic [1:0]  SIZ;
  logic        AS20;
  logic        DS20;
  logic        RW20;
  logic [31:0] D_OUT;
  logic        D_OE;
  logic [31:0] D_IN;
  logic [1:0]  DSACK;
  logic        BERR;

  cpu_bus_master dut (
    .CLKCPU    (CLKCPU),
    .RESET     (RESET),
    .REQ       (REQ),
    .REQ_RW    (REQ_RW),
    .REQ_A     (REQ_A),
    .REQ_LEN   (REQ_LEN),
    .REQ_WDATA (REQ_WDATA),
    .ACK       (ACK),
    .ERR       (ERR),
    .RDATA     (RDATA),
    .BUSY      (BUSY),
    .A         (A),
    .SIZ       (SIZ),
    .AS20      (AS20),
    .DS20      (DS20),
    .RW20      (RW20),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .D_IN      (D_IN),
    .DSACK     (DSACK),
    .BERR      (BERR)
  );

  // 100 MHz-style bus clock
  initial begin
    CLKCPU = 1'b0;
    forever #5 CLKCPU = ~CLKCPU;
  end

  typedef struct {
    logic            rw;
    logic [23:0]     addr;
    logic [1:0]      len;
    logic [31:0]     wdata;
    logic [1:0]      dsack;
    logic            berr;
    logic [0:3][31:0] din;
    int              expCycles;
    logic [0:1][23:0] expA;
    logic [0:1][1:0]  expSiz;
    logic [0:1][31:0] expDout;
    int              expAckIdx;
    logic [31:0]     expRdata;
    logic            expErr;
  } vec_t;

  int nCompared;
  int nMismatched;

  // Observations of the most recent transaction
  logic [23:0] capA   [4];
  logic [1:0]  capSiz [4];
  logic [31:0] capDout[4];
  int          nCycles;
  int          ackIdx;
  int          dsLowCount;
  logic        gotAck;
  logic        gotErr;
  logic [31:0] gotRdata;
  logic        busyAtAck;
  logic        busyAfter;

  vec_t vecs [8];
  vec_t tv;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issue one request and act as the responder until ACK or the cycle budget runs out
  task automatic applyStimulus(input vec_t v);
    int  idx;
    logic prevAs;
    @(negedge CLKCPU);
    REQ       = 1'b1;
    REQ_RW    = v.rw;
    REQ_A     = v.addr;
    REQ_LEN   = v.len;
    REQ_WDATA = v.wdata;
    DSACK     = 2'b11;
    BERR      = 1'b1;
    @(posedge CLKCPU);
    @(negedge CLKCPU);
    REQ        = 1'b0;
    idx        = 0;
    prevAs     = 1'b1;
    nCycles    = 0;
    dsLowCount = 0;
    gotAck     = 1'b0;
    ackIdx     = -1;
    while (!gotAck && idx < 400) begin
      if (AS20 == 1'b0 && prevAs == 1'b1) begin
        if (nCycles < 4) begin
          capA[2'(nCycles)]    = A;
          capSiz[2'(nCycles)]  = SIZ;
          capDout[2'(nCycles)] = D_OUT;
          D_IN                 = v.din[2'(nCycles)];
        end
        nCycles++;
      end
      if (DS20 == 1'b0) dsLowCount++;
      if (AS20 == 1'b0) begin
        DSACK = v.dsack;
        BERR  = v.berr;
      end else begin
        DSACK = 2'b11;
        BERR  = 1'b1;
      end
      if (ACK) begin
        gotAck    = 1'b1;
        ackIdx    = idx;
        gotErr    = ERR;
        gotRdata  = RDATA;
        busyAtAck = BUSY;
      end
      prevAs = AS20;
      if (!gotAck) begin
        @(negedge CLKCPU);
        idx++;
      end
    end
    DSACK = 2'b11;
    BERR  = 1'b1;
    @(negedge CLKCPU);
    busyAfter = BUSY;
  endtask

  initial begin
    int sawAck;
    nCompared   = 0;
    nMismatched = 0;
    RESET     = 1'b1;
    REQ       = 1'b0;
    REQ_RW    = 1'b1;
    REQ_A     = '0;
    REQ_LEN   = '0;
    REQ_WDATA = '0;
    D_IN      = '0;
    DSACK     = 2'b11;
    BERR      = 1'b1;

    repeat (3) @(posedge CLKCPU);
    @(negedge CLKCPU);
    checkOutput("rst_AS20", AS20, 1);
    checkOutput("rst_DS20", DS20, 1);
    checkOutput("rst_RW20", RW20, 1);
    checkOutput("rst_D_OE", D_OE, 0);
    checkOutput("rst_A", A, 0);
    checkOutput("rst_SIZ", SIZ, 0);
    checkOutput("rst_D_OUT", D_OUT, 0);
    checkOutput("rst_ACK", ACK, 0);
    checkOutput("rst_ERR", ERR, 0);
    checkOutput("rst_RDATA", RDATA, 0);
    checkOutput("rst_BUSY", BUSY, 0);
    RESET = 1'b0;

    vecs[0] = '{rw:1'b1, addr:24'h000100, len:2'b00, wdata:32'h0, dsack:2'b00, berr:1'b1,
                din:{32'h11223344, 96'h0}, expCycles:1, expA:{24'h000100, 24'h0},
                expSiz:{2'b00, 2'b00}, expDout:{32'h0, 32'h0}, expAckIdx:4, expRdata:32'h11223344, expErr:1'b0};
    vecs[1] = '{rw:1'b0, addr:24'h000001, len:2'b00, wdata:32'hAABBCCDD, dsack:2'b00, berr:1'b1,
                din:128'h0, expCycles:2, expA:{24'h000001, 24'h000004},
                expSiz:{2'b00, 2'b01}, expDout:{32'hAAAABBCC, 32'hDDDDDDDD}, expAckIdx:8, expRdata:32'h0, expErr:1'b0};
    vecs[2] = '{rw:1'b1, addr:24'h000200, len:2'b00, wdata:32'h0, dsack:2'b01, berr:1'b1,
                din:{32'h1234ABCD, 32'h5678EF01, 64'h0}, expCycles:2, expA:{24'h000200, 24'h000202},
                expSiz:{2'b00, 2'b10}, expDout:{32'h0, 32'h0}, expAckIdx:8, expRdata:32'h12345678, expErr:1'b0};
    vecs[3] = '{rw:1'b0, addr:24'h000003, len:2'b01, wdata:32'h0000005A, dsack:2'b10, berr:1'b1,
                din:128'h0, expCycles:1, expA:{24'h000003, 24'h0},
                expSiz:{2'b01, 2'b00}, expDout:{32'h5A5A5A5A, 32'h0}, expAckIdx:4, expRdata:32'h0, expErr:1'b0};
    vecs[4] = '{rw:1'b1, addr:24'h000003, len:2'b10, wdata:32'h0, dsack:2'b00, berr:1'b1,
                din:{32'hAABBCCDD, 32'h11223344, 64'h0}, expCycles:2, expA:{24'h000003, 24'h000004},
                expSiz:{2'b10, 2'b01}, expDout:{32'h0, 32'h0}, expAckIdx:8, expRdata:32'h0000DD11, expErr:1'b0};
    vecs[5] = '{rw:1'b1, addr:24'hFFFFFF, len:2'b11, wdata:32'h0, dsack:2'b10, berr:1'b1,
                din:{32'hA1000000, 32'hB2000000, 32'hC3000000, 32'h0}, expCycles:3, expA:{24'hFFFFFF, 24'h000000},
                expSiz:{2'b11, 2'b10}, expDout:{32'h0, 32'h0}, expAckIdx:12, expRdata:32'h00A1B2C3, expErr:1'b0};
    vecs[6] = '{rw:1'b0, addr:24'h000010, len:2'b00, wdata:32'hCAFEF00D, dsack:2'b01, berr:1'b1,
                din:128'h0, expCycles:2, expA:{24'h000010, 24'h000012},
                expSiz:{2'b00, 2'b10}, expDout:{32'hCAFEF00D, 32'hF00DF00D}, expAckIdx:8, expRdata:32'h0, expErr:1'b0};
    vecs[7] = '{rw:1'b1, addr:24'h000300, len:2'b00, wdata:32'h0, dsack:2'b00, berr:1'b0,
                din:{32'h99999999, 96'h0}, expCycles:1, expA:{24'h000300, 24'h0},
                expSiz:{2'b00, 2'b00}, expDout:{32'h0, 32'h0}, expAckIdx:4, expRdata:32'h0, expErr:1'b1};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_ack_seen", i), gotAck, 1);
      checkOutput($sformatf("v%0d_cycles", i), nCycles, vecs[i].expCycles);
      checkOutput($sformatf("v%0d_ack_idx", i), ackIdx, vecs[i].expAckIdx);
      checkOutput($sformatf("v%0d_err", i), gotErr, vecs[i].expErr);
      checkOutput($sformatf("v%0d_busy_at_ack", i), busyAtAck, 1);
      checkOutput($sformatf("v%0d_busy_after", i), busyAfter, 0);
      for (int c = 0; c < vecs[i].expCycles && c < 2; c++) begin
        checkOutput($sformatf("v%0d_c%0d_A", i, c), capA[2'(c)], vecs[i].expA[c[0]]);
        checkOutput($sformatf("v%0d_c%0d_SIZ", i, c), capSiz[2'(c)], vecs[i].expSiz[c[0]]);
        if (!vecs[i].rw) begin
          checkOutput($sformatf("v%0d_c%0d_D_OUT", i, c), capDout[2'(c)], vecs[i].expDout[c[0]]);
        end
      end
      if (vecs[i].rw && !vecs[i].expErr) begin
        checkOutput($sformatf("v%0d_rdata", i), gotRdata, vecs[i].expRdata);
      end
    end

    // Timeout: no termination at all, write so DS20 is low only in WAIT
    tv       = vecs[3];
    tv.addr  = 24'h000500;
    tv.dsack = 2'b11;
    applyStimulus(tv);
    checkOutput("tmo_ack_seen", gotAck, 1);
    checkOutput("tmo_err", gotErr, 1);
    checkOutput("tmo_wait_cycles", dsLowCount, 255);
    checkOutput("tmo_cycles", nCycles, 1);
    checkOutput("tmo_ack_idx", ackIdx, 258);

    // Reset while the master sits in WAIT
    @(negedge CLKCPU);
    REQ     = 1'b1;
    REQ_RW  = 1'b1;
    REQ_A   = 24'h000400;
    REQ_LEN = 2'b00;
    DSACK   = 2'b11;
    @(posedge CLKCPU);
    @(negedge CLKCPU);
    REQ = 1'b0;
    repeat (3) @(negedge CLKCPU);
    checkOutput("rstw_in_wait_AS20", AS20, 0);
    checkOutput("rstw_in_wait_DS20", DS20, 0);
    RESET = 1'b1;
    @(posedge CLKCPU);
    @(negedge CLKCPU);
    checkOutput("rstw_AS20", AS20, 1);
    checkOutput("rstw_DS20", DS20, 1);
    checkOutput("rstw_ACK", ACK, 0);
    checkOutput("rstw_BUSY", BUSY, 0);
    RESET  = 1'b0;
    sawAck = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLKCPU);
      if (ACK) sawAck++;
    end
    checkOutput("rstw_no_ack", sawAck, 0);
    applyStimulus(vecs[0]);
    checkOutput("rstw_new_ack_seen", gotAck, 1);
    checkOutput("rstw_new_rdata", gotRdata, 32'h11223344);
    checkOutput("rstw_new_err", gotErr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
